// File: rtl/fetch_line_buffer_if.sv
// Sysbus request/response plus decode-side instruction handshake for fetch_line_buffer.
// master = fetch unit side, slave = bus/decode environment side.
interface fetch_line_buffer_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [63:0]               bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;
  logic                      inst_valid;
  logic [31:0]               inst;
  logic [63:0]               inst_pc;
  logic                      inst_ready;
  logic                      redirect_valid;
  logic [63:0]               redirect_pc;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output inst_valid, inst, inst_pc,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  inst_valid, inst, inst_pc,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// Instruction fetch: reads 64-byte lines over Sysbus, hands out 32-bit words to decode.
// Define FETCH_TRACE_EN to print accepted instructions and the halt PC in simulation.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module fetch_line_buffer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         entry,
  output logic                halted,
  fetch_line_buffer_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam int unsigned TAG_VAL = (int'(`SYSBUS_READ) << 12) | (int'(`SYSBUS_MEMORY) << 8);
  localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG = BUS_TAG_WIDTH'(TAG_VAL);

  logic [2:0]                state;
  logic [63:0]               pc;
  logic [2:0]                beat_cnt;
  logic                      redirect_pending;
  logic [63:2]               pending_pc;
  logic [BUS_DATA_WIDTH-1:0] line_buf [LINE_BEATS];

  logic [BUS_DATA_WIDTH-1:0] cur_beat;
  logic [31:0]               cur_word;
  logic                      word_zero;
  logic                      last_beat;
  logic                      take;
  logic                      unused_bits;

  assign cur_beat    = line_buf[pc[5:3]];
  assign cur_word    = pc[2] ? cur_beat[63:32] : cur_beat[31:0];
  assign word_zero   = (cur_word == '0);
  assign last_beat   = (beat_cnt == 3'(LINE_BEATS - 1));
  assign take        = (state == S_DRAIN) && !word_zero && bus.inst_ready;
  assign halted      = (state == S_HALT);
  assign unused_bits = ^{entry[1:0], bus.redirect_pc[1:0], bus.bus_resptag};

  always_comb begin
    bus.bus_reqcyc  = 1'b0;
    bus.bus_req     = '0;
    bus.bus_reqtag  = '0;
    bus.bus_respack = (state == S_RESP) && bus.bus_respcyc;
    bus.inst_valid  = 1'b0;
    bus.inst        = '0;
    bus.inst_pc     = '0;
    if (state == S_REQ) begin
      bus.bus_reqcyc = 1'b1;
      bus.bus_req    = {pc[63:6], 6'b0};
      bus.bus_reqtag = REQ_TAG;
    end
    if (state == S_DRAIN) begin
      bus.inst_valid = !word_zero;
      bus.inst       = cur_word;
      bus.inst_pc    = pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      pc               <= '0;
      beat_cnt         <= '0;
      redirect_pending <= 1'b0;
      pending_pc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          pc    <= {entry[63:2], 2'b00};
          state <= S_REQ;
        end
        S_REQ: begin
          if (bus.redirect_valid) begin
            redirect_pending <= 1'b1;
            pending_pc       <= bus.redirect_pc[63:2];
          end
          if (bus.bus_reqack) begin
            state    <= S_RESP;
            beat_cnt <= '0;
          end
        end
        S_RESP: begin
          if (bus.redirect_valid) begin
            redirect_pending <= 1'b1;
            pending_pc       <= bus.redirect_pc[63:2];
          end
          if (bus.bus_respcyc) begin
            beat_cnt <= beat_cnt + 3'd1;
            // A redirect seen during the burst lets it finish, then refetches at the newest target.
            if (last_beat) begin
              redirect_pending <= 1'b0;
              if (bus.redirect_valid) begin
                pc    <= {bus.redirect_pc[63:2], 2'b00};
                state <= S_REQ;
              end else if (redirect_pending) begin
                pc    <= {pending_pc, 2'b00};
                state <= S_REQ;
              end else begin
                state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (bus.redirect_valid) begin
            pc    <= {bus.redirect_pc[63:2], 2'b00};
            state <= S_REQ;
          end else if (word_zero) begin
            state <= S_HALT;
          end else if (bus.inst_ready) begin
            pc <= pc + 64'd4;
            if (pc[5:2] == 4'hF) state <= S_REQ;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RESP && bus.bus_respcyc) line_buf[beat_cnt] <= bus.bus_resp;
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (take) $display("%h %h", bus.inst_pc, bus.inst);
      if (state == S_DRAIN && !bus.redirect_valid && word_zero) $display("halt %h", pc);
    end
  end
`else
  // trace output compiled out; datapath is unchanged
`endif

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Scoreboard bench for fetch_line_buffer: directed programs, queued expectations, negedge monitor.
module tb_fetch_line_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] entry = '0;
  logic        halted;

  fetch_line_buffer_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) fl ();

  fetch_line_buffer #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .LINE_BEATS(8)) dut (
    .clk(clk), .reset(reset), .entry(entry), .halted(halted), .bus(fl)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [logic [63:0]];
  logic [63:0] exp_req [$];
  logic [95:0] exp_inst [$];

  int ack_delay = 0;
  int beat_gap = 0;
  bit ready_toggle = 0;
  bit ready_low = 0;
  bit stray_beat = 0;
  int beats_sent = 0;
  bit beat_ack_exp = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [95:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hBEEF, a[15:0]};
  endfunction

  // bus responder: acks requests after ack_delay cycles, then streams 8 beats with beat_gap idle cycles
  initial begin
    int wait_cnt, gap_cnt, beats;
    bit busy, acking, consumed;
    logic [63:0] line;
    fl.bus_reqack = 0; fl.bus_respcyc = 0; fl.bus_resp = '0; fl.bus_resptag = '0;
    busy = 0; acking = 0; wait_cnt = 0; gap_cnt = 0; beats = 0; line = '0;
    forever begin
      @(posedge clk); #1;
      consumed = fl.bus_respcyc && beat_ack_exp;
      fl.bus_respcyc = 0;
      if (reset) begin
        busy = 0; acking = 0; wait_cnt = 0; beats = 0; beats_sent = 0;
        fl.bus_reqack = 0;
        continue;
      end
      if (acking) begin
        acking = 0; fl.bus_reqack = 0; busy = 1; beats = 0; gap_cnt = 0; beats_sent = 0;
      end else if (busy) begin
        if (consumed) beats++;
        beats_sent = beats;
        if (beats == 8) busy = 0;
        else if (gap_cnt < beat_gap) gap_cnt++;
        else begin
          gap_cnt = 0;
          fl.bus_respcyc = 1;
          beat_ack_exp = 1;
          fl.bus_resp = {mem_word(line + 64'(8 * beats + 4)), mem_word(line + 64'(8 * beats))};
        end
      end else if (stray_beat) begin
        stray_beat = 0;
        fl.bus_respcyc = 1;
        beat_ack_exp = 0;
        fl.bus_resp = '1;
      end else if (fl.bus_reqcyc) begin
        if (wait_cnt >= ack_delay) begin
          fl.bus_reqack = 1; acking = 1; line = fl.bus_req; wait_cnt = 0;
        end else wait_cnt++;
      end
    end
  end

  initial begin
    fl.inst_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (ready_low) fl.inst_ready = 0;
      else if (ready_toggle) fl.inst_ready = ~fl.inst_ready;
      else fl.inst_ready = 1;
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a request, beat ack or instruction
  initial begin
    logic [63:0] prev_req;
    logic [63:0] e;
    logic [95:0] ei;
    bit prev_wait;
    prev_wait = 0; prev_req = '0;
    forever begin
      @(negedge clk);
      if (reset) begin prev_wait = 0; continue; end
      if (fl.bus_reqcyc) begin
        if (prev_wait) check("req_stable", fl.bus_req, prev_req);
        if (fl.bus_reqack) begin
          if (exp_req.size() == 0) unexpected("req", {32'h0, fl.bus_req});
          else begin
            e = exp_req.pop_front();
            check("req_addr_tag", {fl.bus_reqtag, fl.bus_req}, {13'h1100, e});
          end
          prev_wait = 0;
        end else begin
          prev_wait = 1; prev_req = fl.bus_req;
        end
      end else prev_wait = 0;
      if (fl.bus_respcyc) check("respack", fl.bus_respack, beat_ack_exp);
      if (fl.inst_valid && fl.inst_ready) begin
        if (exp_inst.size() == 0) unexpected("inst", {fl.inst_pc, fl.inst});
        else begin
          ei = exp_inst.pop_front();
          check("inst_pc_word", {fl.inst_pc, fl.inst}, ei);
        end
      end
    end
  end

  task automatic push_inst(input logic [63:0] pc, input logic [31:0] w);
    exp_inst.push_back({pc, w});
  endtask

  task automatic assert_reset(input string name);
    #2 reset = 1;
    #1 check(name, {fl.bus_reqcyc, fl.bus_req, fl.bus_reqtag, fl.bus_respack, fl.inst_valid,
                    fl.inst, fl.inst_pc, halted}, '0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic wait_done(input string name);
    bit saw;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (halted && exp_req.size() == 0 && exp_inst.size() == 0) break;
    end
    check({name, "_done"}, {halted, fl.inst_valid, 16'(exp_req.size()), 16'(exp_inst.size())},
          {1'b1, 1'b0, 16'd0, 16'd0});
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw |= fl.bus_reqcyc;
    end
    check({name, "_halt_noreq"}, saw, 1'b0);
  endtask

  task automatic new_test(input logic [63:0] e);
    @(negedge clk);
    assert_reset("reset_values");
    mem.delete();
    exp_req.delete();
    exp_inst.delete();
    ack_delay = 0; beat_gap = 0; ready_toggle = 0; ready_low = 0;
    fl.redirect_valid = 0; fl.redirect_pc = '0;
    entry = e;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fl.redirect_valid = 0;
    fl.redirect_pc = '0;

    // 1: full line from 0x1000, words i+1, then 0x1040 holds the end marker
    new_test(64'h1000);
    for (int i = 0; i < 16; i++) mem[64'h1000 + 64'(4 * i)] = 32'(i + 1);
    mem[64'h1040] = 32'h0;
    exp_req.push_back(64'h1000);
    exp_req.push_back(64'h1040);
    for (int i = 0; i < 16; i++) push_inst(64'h1000 + 64'(4 * i), 32'(i + 1));
    release_reset();
    wait_done("full_line");

    // 2: unaligned entry skips words 0..13
    new_test(64'h1038);
    for (int i = 0; i < 16; i++) mem[64'h1000 + 64'(4 * i)] = 32'(i + 1);
    mem[64'h1040] = 32'h0;
    exp_req.push_back(64'h1000);
    exp_req.push_back(64'h1040);
    push_inst(64'h1038, 32'd15);
    push_inst(64'h103C, 32'd16);
    release_reset();
    wait_done("unaligned");

    // 3: slow ack, gapped beats, toggling ready
    new_test(64'h3000);
    ack_delay = 5; beat_gap = 2; ready_toggle = 1;
    mem[64'h3040] = 32'h0;
    exp_req.push_back(64'h3000);
    exp_req.push_back(64'h3040);
    for (int i = 0; i < 16; i++) push_inst(64'h3000 + 64'(4 * i), {16'hBEEF, 16'h3000 + 16'(4 * i)});
    release_reset();
    wait_done("backpressure");

    // 4: redirect to 0x2004 mid-burst
    new_test(64'h4000);
    beat_gap = 1;
    mem[64'h2040] = 32'h0;
    exp_req.push_back(64'h4000);
    exp_req.push_back(64'h2000);
    exp_req.push_back(64'h2040);
    for (int i = 1; i < 16; i++) push_inst(64'h2000 + 64'(4 * i), {16'hBEEF, 16'h2000 + 16'(4 * i)});
    release_reset();
    for (int i = 0; i < 500 && beats_sent < 3; i++) @(negedge clk);
    check("redirect_at_beat3", 32'(beats_sent), 32'd3);
    @(posedge clk); #1;
    fl.redirect_valid = 1; fl.redirect_pc = 64'h2004;
    @(posedge clk); #1;
    fl.redirect_valid = 0;
    wait_done("redirect");

    // 5: zero word at 0x1008 halts after two instructions
    new_test(64'h1000);
    mem[64'h1008] = 32'h0;
    exp_req.push_back(64'h1000);
    push_inst(64'h1000, 32'hBEEF1000);
    push_inst(64'h1004, 32'hBEEF1004);
    release_reset();
    wait_done("zero_halt");

    // 6a: async reset while presenting an instruction, restart from entry
    new_test(64'h5000);
    ready_low = 1;
    mem[64'h5008] = 32'h0;
    exp_req.push_back(64'h5000);
    release_reset();
    for (int i = 0; i < 500 && !fl.inst_valid; i++) @(negedge clk);
    check("drain_reached", fl.inst_valid, 1'b1);
    assert_reset("reset_mid_drain");
    ready_low = 0;
    exp_req.push_back(64'h5000);
    push_inst(64'h5000, 32'hBEEF5000);
    push_inst(64'h5004, 32'hBEEF5004);
    release_reset();
    wait_done("restart_drain");

    // 6b: async reset mid-burst, stray beat after release must not be acked
    new_test(64'h6000);
    beat_gap = 1;
    mem[64'h6008] = 32'h0;
    exp_req.push_back(64'h6000);
    release_reset();
    for (int i = 0; i < 500 && beats_sent < 3; i++) @(negedge clk);
    check("resp_reached", 32'(beats_sent), 32'd3);
    assert_reset("reset_mid_resp");
    beat_gap = 0;
    stray_beat = 1;
    exp_req.push_back(64'h6000);
    push_inst(64'h6000, 32'hBEEF6000);
    push_inst(64'h6004, 32'hBEEF6004);
    release_reset();
    wait_done("restart_resp");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_line_buffer.md
# fetch_line_buffer

Instruction-fetch front end between the system bus and the decode stage. Issues 64-byte line reads on the Sysbus, collects 8 × 64-bit response beats into a line buffer, then hands out one 32-bit instruction per handshake to decode with its PC. Supports an external PC redirect and stops on an all-zero instruction word (end-of-program marker).

## Interface
- BUS_DATA_WIDTH, 64, bus data width; only 64 is supported.
- BUS_TAG_WIDTH, 13, bus tag width.
- LINE_BEATS, 8, beats per line; line = LINE_BEATS × 8 bytes = 64 bytes.
- clk  in  1  clock; one clock domain, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- entry  in  64  program entry PC; sampled in IDLE only.
- bus_reqcyc  out  1  read request valid.
- bus_req  out  64  line-aligned request address.
- bus_reqtag  out  BUS_TAG_WIDTH  constant `SYSBUS_READ<<12 | `SYSBUS_MEMORY<<8 while bus_reqcyc=1; otherwise 0.
- bus_reqack  in  1  request accepted.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  64  response data; [31:0] lower-address instruction.
- bus_resptag  in  BUS_TAG_WIDTH  ignored.
- bus_respack  out  1  beat consumed.
- inst_valid  out  1  instruction available to decode.
- inst  out  32  instruction word.
- inst_pc  out  64  PC of inst.
- inst_ready  in  1  decode accepts inst this cycle.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  64  new PC; bits [1:0] ignored.
- halted  out  1  zero instruction reached; sticky until reset.

## Operation
- States: IDLE, REQ, RESP, DRAIN, HALT.
- IDLE: one cycle after reset release. Load pc ← {entry[63:2],2'b00} -> REQ.
- REQ: bus_reqcyc=1 and bus_req={pc[63:6],6'b0}, held stable until the cycle bus_reqack=1 -> RESP. beat_cnt ← 0.
- RESP: each cycle with bus_respcyc=1, store bus_resp into buf[beat_cnt], assert bus_respack in the same cycle (combinational: state==RESP && bus_respcyc), beat_cnt+1. After beat LINE_BEATS-1 is stored -> DRAIN. Beats arrive in ascending address order from the aligned address.
- DRAIN: inst = 32-bit word pc[5:2] of buf, inst_pc = pc, inst_valid=1 unless the word is 0.
  - On inst_valid && inst_ready: pc ← pc+4. If pc[5:2] was 15, go to REQ (next line); otherwise stay in DRAIN.
  - If the word at pc[5:2] is 32'h0: inst_valid=0 -> HALT.
- Unaligned entry/redirect: words before pc[5:2] in the line are skipped, never presented.
- HALT: halted=1, no bus requests, inst_valid=0. Exit via reset only.
- Redirect (pc ← redirect_pc):
  - In DRAIN: next state REQ. inst_valid=0 from the next cycle; a handshake in the redirect cycle completes and the redirect wins the pc update.
  - In REQ or RESP: latch redirect_pending and redirect PC. The outstanding request/burst completes (all LINE_BEATS beats acked, data discarded), then REQ at the new line. A later redirect overwrites the latched PC.
  - In IDLE: ignored. In HALT: ignored.
- No bus_respcyc outside RESP is expected; any such beat is not acked.

## Timing
- Reset values: bus_reqcyc=0, bus_req=0, bus_reqtag=0, bus_respack=0, inst_valid=0, inst=0, inst_pc=0, halted=0. State=IDLE, beat_cnt=0, redirect_pending=0.
- Async reset mid-burst: all state is cleared immediately. Any in-flight beats after release are not acked.
- Latency: reset release at edge T → bus_reqcyc=1 after edge T+1. Ack seen at edge A → RESP from A. Last beat at edge L → inst_valid=1 after L.
- Throughput: one instruction per cycle in DRAIN. No overlap of fetch with drain.
- Line wrap: pc 0x...3C accepted → bus_reqcyc=1 the next cycle at address pc+4.
- Arithmetic: pc is 64-bit modulo 2^64. beat_cnt is 3 bits and wraps only via the state exit.

## Configuration
- FETCH_TRACE_EN defined: each accepted instruction (inst_valid && inst_ready) emits $display("%h %h", inst_pc, inst). Entering HALT emits $display("halt %h", pc).
- FETCH_TRACE_EN undefined: no simulation output; RTL behaviour is identical.

## Test plan
- Reset, entry=0x1000, beats word_i=i+1 (nonzero), inst_ready=1 → one request to 0x1000 with READ/MEMORY tag; 8 respacks; 16 instructions with inst_pc 0x1000..0x103C in order; next request to 0x1040.
- entry=0x1038 → request 0x1000; only words 14,15 presented (pc 0x1038, 0x103C); then request to 0x1040.
- bus_reqack delayed 5 cycles, beats spaced with idle gaps, inst_ready toggling 1/0 → bus_req stable until ack; no beat lost or duplicated; no instruction duplicated or skipped.
- redirect_valid with redirect_pc=0x2004 at beat 3 of a burst → remaining 5 beats acked and discarded; next request 0x2000; first inst_pc=0x2004.
- Word at 0x1008 = 0 → 0x1000, 0x1004 presented; then halted=1, inst_valid=0, no further bus_reqcyc.
- Async reset asserted mid-DRAIN and mid-RESP → all outputs reach reset values without a clock edge; fetch restarts from entry after release.
